// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module      : mult_div_unit_if
// Description : Request/response bundle for the iterative multiply/divide
//               unit. The master (pipeline side) drives start, cancel, op and
//               the operands. The slave (mult_div_unit) returns busy, the
//               one-cycle done pulse and the hi/lo result pair.
// Ports       : start, cancel, op[1:0], srcA, srcB     (master -> slave)
//               busy, done, hiOut, loOut                (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             cancel;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;

    modport master (
        output start, cancel, op, srcA, srcB,
        input  busy, done, hiOut, loOut
    );

    modport slave (
        input  start, cancel, op, srcA, srcB,
        output busy, done, hiOut, loOut
    );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. Signed
//               operands are reduced to magnitudes on launch, WIDTH iterations
//               of shift-add (multiply) or restoring division are run, and a
//               final cycle applies sign correction and registers {hi, lo}.
//               Start edge to done pulse is WIDTH+1 cycles.
// Ports       : CLK        clock, all state on posedge
//               RST        asynchronous reset, active-high
//               bus        mult_div_unit_if slave modport
//                          (start, cancel, op, srcA, srcB -> busy, done,
//                           hiOut, loOut)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    mult_div_unit_if.slave       bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    // Working registers. For multiply {acc_hi, acc_lo} is {P, multiplier}
    // and opnd holds the multiplicand magnitude. For divide {acc_hi, acc_lo}
    // is {R, Q} with Q initially the dividend magnitude, and opnd holds the
    // divisor magnitude.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_lo;     // negate product / quotient
    logic             neg_hi;     // remainder follows dividend sign
    logic             div_zero;
    logic [WIDTH-1:0] dividend;   // raw srcA, returned as hi on divide by zero

    // Launch-time operand conditioning
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // One iteration of each algorithm
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        // Signed ops have op[0]==0; magnitude of the most negative value
        // still fits the unsigned WIDTH-bit range.
        a_neg = ~bus.op[0] & bus.srcA[WIDTH-1];
        b_neg = ~bus.op[0] & bus.srcB[WIDTH-1];
        mag_a = a_neg ? (~bus.srcA + 1'b1) : bus.srcA;
        mag_b = b_neg ? (~bus.srcB + 1'b1) : bus.srcB;

        // Shift-add: add multiplicand when the multiplier LSB is set; the
        // carry bit feeds the right shift of {P, multiplier}.
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

        // Restoring divide: shifted partial remainder needs one extra bit.
        div_tmp  = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_tmp - {1'b0, opnd};
        div_ge   = (div_tmp >= {1'b0, opnd});

        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        quo_fix  = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            count    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= CALC;
                        count    <= '0;
                        busy_r   <= 1'b1;
                        is_div   <= bus.op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= a_neg;
                        div_zero <= bus.op[1] & (bus.srcB == '0);
                        dividend <= bus.srcA;
                        acc_hi   <= '0;
                        if (bus.op[1]) begin
                            acc_lo <= mag_a;
                            opnd   <= mag_b;
                        end else begin
                            acc_lo <= mag_b;
                            opnd   <= mag_a;
                        end
                    end
                end

                CALC: begin
                    if (bus.cancel) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        if (is_div) begin
                            if (div_ge) begin
                                acc_hi <= div_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                acc_hi <= div_tmp[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end

                FIX: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    if (!bus.cancel) begin
                        done_r <= 1'b1;
                        if (!is_div) begin
                            hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix[WIDTH-1:0];
                        end else if (div_zero) begin
                            hi_r <= dividend;
                            lo_r <= '1;
                        end else begin
                            hi_r <= rem_fix;
                            lo_r <= quo_fix;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hiOut = hi_r;
    assign bus.loOut = lo_r;

endmodule

`default_nettype wire
